// File: rtl/bank_pkg.sv
// ============================================================================
// Module   : bank_pkg
// Brief    : Shared constants, register map and FSM state type for submod_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_pkg;

    localparam int REG_BASE = 'h000;
    localparam int RAM_BASE = 'h100;
    localparam int EXT_BASE = 'h200;

    localparam logic [7:0] REG_ID     = 8'h00;
    localparam logic [7:0] REG_CTRL   = 8'h01;
    localparam logic [7:0] REG_STATUS = 8'h02;

    localparam logic [31:0] BANK_ID = 32'h0BA2_0002;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCAL    = 2'd1,
        EXT_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Event counters stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/submod_bank_if.sv
// ============================================================================
// Module   : submod_bank_if
// Brief    : Ghostbus host port plus external sub-bus of the RAM bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface submod_bank_if #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int EXT_AW = 2,
    parameter int EXT_DW = 8
);
    logic [AW-1:0]     gb_addr;
    logic [DW-1:0]     gb_wdata;
    logic              gb_we;
    logic              gb_re;
    logic [DW-1:0]     gb_rdata;
    logic              gb_ack;
    logic [EXT_AW-1:0] ext_addr;
    logic [EXT_DW-1:0] ext_wdata;
    logic              ext_we;
    logic              ext_re;
    logic [EXT_DW-1:0] ext_rdata;
    logic              ext_ack;

    // The bank is the slave on the host side and the initiator on the ext side.
    modport slave (
        input  gb_addr, gb_wdata, gb_we, gb_re, ext_rdata, ext_ack,
        output gb_rdata, gb_ack, ext_addr, ext_wdata, ext_we, ext_re
    );

    modport master (
        output gb_addr, gb_wdata, gb_we, gb_re, ext_rdata, ext_ack,
        input  gb_rdata, gb_ack, ext_addr, ext_wdata, ext_we, ext_re
    );
endinterface

`default_nettype wire

// File: rtl/bank_ram.sv
// ============================================================================
// Module   : bank_ram
// Brief    : Single-port RAM, synchronous write, registered read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_ram #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic          i_re,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [DW-1:0] i_wdata,
    output logic      [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/submod_bank.sv
// ============================================================================
// Module   : submod_bank
// Brief    : Multi-channel RAM bank with control/status registers and a
//            handshaked external window. Macro SUBMOD_BANK_TIMEOUT_EN enables
//            the ext_ack timeout and its STATUS counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module submod_bank
    import bank_pkg::*;
#(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int NCH     = 4,
    parameter int RAM_AW  = 6,
    parameter int RAM_DW  = 8,
    parameter int EXT_AW  = 2,
    parameter int EXT_DW  = 8,
    parameter int TIMEOUT = 15
) (
    input  wire logic     clk,
    input  wire logic     rst,
    submod_bank_if.slave  bus
);
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RAM_SPAN = NCH * (2**RAM_AW);
    localparam int EXT_SPAN = 2**EXT_AW;

    localparam logic [AW-9:0] c_reg_page = (AW-8)'(REG_BASE / 256);
    localparam logic [AW-9:0] c_ram_page = (AW-8)'(RAM_BASE / 256);
    localparam logic [AW-9:0] c_ext_page = (AW-8)'(EXT_BASE / 256);

    state_t              r_state;
    logic [DW-1:0]       r_rdata;
    logic                r_ack;
    logic [EXT_AW-1:0]   r_ext_addr;
    logic [EXT_DW-1:0]   r_ext_wdata;
    logic                r_ext_we;
    logic                r_ext_re;
    logic                r_wlock;
    logic [7:0]          r_ovr;
    logic                r_is_rd;
    logic                r_rd_ram;
    logic [CH_W-1:0]     r_ch;
    logic [DW-1:0]       r_reg_val;
`ifdef SUBMOD_BANK_TIMEOUT_EN
    logic [7:0]          r_tmo;
    logic [7:0]          r_wait;
`endif

    logic [AW-9:0]       w_page;
    logic [7:0]          w_off;
    logic                w_reg_hit;
    logic                w_ram_hit;
    logic                w_ext_hit;
    logic                w_idle;
    logic                w_req;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [CH_W-1:0]     w_ch;
    logic [7:0]          w_tmo_byte;
    logic [31:0]         w_status;
    logic [DW-1:0]       w_reg_rd;
    logic [RAM_DW-1:0]   w_ram_rdata [NCH];
    logic                w_unused_bits;

    assign w_page    = bus.gb_addr[AW-1:8];
    assign w_off     = bus.gb_addr[7:0];
    assign w_reg_hit = (w_page == c_reg_page) && (w_off <= REG_STATUS);
    assign w_ram_hit = (w_page == c_ram_page) && ({1'b0, w_off} < 9'(RAM_SPAN));
    assign w_ext_hit = (w_page == c_ext_page) && ({1'b0, w_off} < 9'(EXT_SPAN));

    assign w_idle = (r_state == IDLE);
    assign w_req  = bus.gb_we | bus.gb_re;

    // Write wins over a simultaneous read; a write under reset must not land.
    assign w_ram_we = w_idle && bus.gb_we && w_ram_hit && !r_wlock && !rst;
    assign w_ram_re = w_idle && !bus.gb_we && bus.gb_re && w_ram_hit;

    generate
        if (NCH > 1) begin : g_ch_sel
            assign w_ch = bus.gb_addr[RAM_AW+CH_W-1:RAM_AW];
        end else begin : g_ch_one
            assign w_ch = 1'b0;
        end

        for (genvar g = 0; g < NCH; g++) begin : g_ch
            bank_ram #(
                .AW (RAM_AW),
                .DW (RAM_DW)
            ) u_ram (
                .clk     (clk),
                .i_we    (w_ram_we && (w_ch == CH_W'(g))),
                .i_re    (w_ram_re && (w_ch == CH_W'(g))),
                .i_addr  (bus.gb_addr[RAM_AW-1:0]),
                .i_wdata (bus.gb_wdata[RAM_DW-1:0]),
                .o_rdata (w_ram_rdata[g])
            );
        end
    endgenerate

`ifdef SUBMOD_BANK_TIMEOUT_EN
    assign w_tmo_byte = r_tmo;
`else
    assign w_tmo_byte = 8'h00;
`endif

    assign w_status = {16'h0000, r_ovr, w_tmo_byte};

    always_comb begin
        w_reg_rd = '0;
        case (w_off)
            REG_ID:     w_reg_rd = DW'(BANK_ID);
            REG_CTRL:   w_reg_rd = DW'(r_wlock);
            REG_STATUS: w_reg_rd = DW'(w_status);
            default:    w_reg_rd = '0;
        endcase
    end

    assign w_unused_bits = ^{bus.gb_wdata, 8'(TIMEOUT)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ext_we    <= 1'b0;
            r_ext_re    <= 1'b0;
            r_wlock     <= 1'b0;
            r_ovr       <= 8'h00;
            r_is_rd     <= 1'b0;
            r_rd_ram    <= 1'b0;
            r_ch        <= '0;
            r_reg_val   <= '0;
`ifdef SUBMOD_BANK_TIMEOUT_EN
            r_tmo       <= 8'h00;
            r_wait      <= 8'h00;
`endif
        end else begin
            r_ack <= 1'b0;
            if (w_req && !w_idle) r_ovr <= sat_inc(r_ovr);

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_is_rd   <= !bus.gb_we;
                        r_rd_ram  <= w_ram_hit;
                        r_ch      <= w_ch;
                        r_reg_val <= w_reg_hit ? w_reg_rd : '0;
                        if (w_ext_hit) begin
                            r_ext_addr  <= bus.gb_addr[EXT_AW-1:0];
                            r_ext_wdata <= bus.gb_wdata[EXT_DW-1:0];
                            r_ext_we    <= bus.gb_we;
                            r_ext_re    <= !bus.gb_we;
`ifdef SUBMOD_BANK_TIMEOUT_EN
                            r_wait      <= 8'h00;
`endif
                            r_state     <= EXT_WAIT;
                        end else begin
                            if (bus.gb_we && w_reg_hit && (w_off == REG_CTRL))
                                r_wlock <= bus.gb_wdata[0];
                            if (bus.gb_we && w_reg_hit && (w_off == REG_STATUS)) begin
                                r_ovr <= 8'h00;
`ifdef SUBMOD_BANK_TIMEOUT_EN
                                r_tmo <= 8'h00;
`endif
                            end
                            r_state <= LOCAL;
                        end
                    end
                end

                LOCAL: begin
                    if (r_is_rd)
                        r_rdata <= r_rd_ram ? DW'(w_ram_rdata[r_ch]) : r_reg_val;
                    r_ack   <= 1'b1;
                    r_state <= RESP;
                end

                EXT_WAIT: begin
                    if (bus.ext_ack) begin
                        r_ext_we <= 1'b0;
                        r_ext_re <= 1'b0;
                        if (r_is_rd) r_rdata <= DW'(bus.ext_rdata);
                        r_ack    <= 1'b1;
                        r_state  <= RESP;
                    end
`ifdef SUBMOD_BANK_TIMEOUT_EN
                    // Counter starts at 0 on entry, so this fires at cycle TIMEOUT+1.
                    else if (r_wait == 8'(TIMEOUT)) begin
                        r_ext_we <= 1'b0;
                        r_ext_re <= 1'b0;
                        if (r_is_rd) r_rdata <= '1;
                        r_tmo    <= sat_inc(r_tmo);
                        r_ack    <= 1'b1;
                        r_state  <= RESP;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
`endif
                end

                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gb_rdata  = r_rdata;
    assign bus.gb_ack    = r_ack;
    assign bus.ext_addr  = r_ext_addr;
    assign bus.ext_wdata = r_ext_wdata;
    assign bus.ext_we    = r_ext_we;
    assign bus.ext_re    = r_ext_re;
endmodule

`default_nettype wire

// File: tb/tb_submod_bank.sv
// ============================================================================
// Module   : tb_submod_bank
// Brief    : Directed self-checking bench for submod_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_submod_bank;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    submod_bank_if #(.AW(24), .DW(32), .EXT_AW(2), .EXT_DW(8)) bus ();

    submod_bank #(
        .AW(24), .DW(32), .NCH(4), .RAM_AW(6), .RAM_DW(8),
        .EXT_AW(2), .EXT_DW(8), .TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request at cycle 0 and returns the cycle gb_ack was seen (-1 if none).
    task automatic host_req(input logic we, input logic re, input logic [23:0] addr,
                            input logic [31:0] wd, input int budget,
                            output logic [31:0] rd, output int lat);
        rd  = '0;
        lat = -1;
        bus.gb_addr  = addr;
        bus.gb_wdata = wd;
        bus.gb_we    = we;
        bus.gb_re    = re;
        tick();
        bus.gb_we = 1'b0;
        bus.gb_re = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (bus.gb_ack) begin
                lat = c;
                rd  = bus.gb_rdata;
                break;
            end
            tick();
        end
        if (lat > 0) tick();
    endtask

    logic [31:0] rd;
    int          lat;
    int          ack_seen;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst           = 1'b1;
        bus.gb_addr   = '0;
        bus.gb_wdata  = '0;
        bus.gb_we     = 1'b0;
        bus.gb_re     = 1'b0;
        bus.ext_rdata = '0;
        bus.ext_ack   = 1'b0;

        tick();
        tick();
        check("rst_rdata", bus.gb_rdata, 32'h0);
        check("rst_ack", 32'(bus.gb_ack), 32'h0);
        check("rst_ext", {22'h0, bus.ext_addr, bus.ext_wdata}, 32'h0);
        check("rst_strobes", {30'h0, bus.ext_we, bus.ext_re}, 32'h0);
        #2 rst = 1'b0;
        tick();

        host_req(1'b0, 1'b1, 24'h000, 32'h0, 10, rd, lat);
        check("id_lat", 32'(lat), 32'd2);
        check("id_val", rd, 32'h0BA2_0002);
        tick();
        check("rdata_hold", bus.gb_rdata, 32'h0BA2_0002);

        // RAM channel 2, word 5
        host_req(1'b1, 1'b0, 24'h185, 32'h0000_01A5, 10, rd, lat);
        check("ramwr_lat", 32'(lat), 32'd2);
        host_req(1'b0, 1'b1, 24'h185, 32'h0, 10, rd, lat);
        check("ramrd_lat", 32'(lat), 32'd2);
        check("ramrd_val", rd, 32'h0000_00A5);

        host_req(1'b1, 1'b0, 24'h001, 32'h1, 10, rd, lat);
        host_req(1'b0, 1'b1, 24'h001, 32'h0, 10, rd, lat);
        check("ctrl_rd", rd, 32'h1);
        host_req(1'b1, 1'b0, 24'h185, 32'h33, 10, rd, lat);
        check("locked_wr_lat", 32'(lat), 32'd2);
        host_req(1'b0, 1'b1, 24'h185, 32'h0, 10, rd, lat);
        check("locked_keep", rd, 32'h0000_00A5);

        host_req(1'b1, 1'b0, 24'h001, 32'h0, 10, rd, lat);
        host_req(1'b1, 1'b0, 24'h1C5, 32'hFFFF_FF11, 10, rd, lat);
        host_req(1'b0, 1'b1, 24'h1C5, 32'h0, 10, rd, lat);
        check("ch3_val", rd, 32'h0000_0011);
        host_req(1'b0, 1'b1, 24'h185, 32'h0, 10, rd, lat);
        check("ch2_indep", rd, 32'h0000_00A5);

        // we and re together act as a write
        host_req(1'b1, 1'b1, 24'h101, 32'h5C, 10, rd, lat);
        check("wr_rd_lat", 32'(lat), 32'd2);
        host_req(1'b0, 1'b1, 24'h101, 32'h0, 10, rd, lat);
        check("wr_rd_val", rd, 32'h0000_005C);

        host_req(1'b0, 1'b1, 24'h204, 32'h0, 10, rd, lat);
        check("unmap_lat", 32'(lat), 32'd2);
        check("unmap_val", rd, 32'h0);
        host_req(1'b0, 1'b1, 24'h003, 32'h0, 10, rd, lat);
        check("unmap_reg", rd, 32'h0);

        bus.ext_ack = 1'b1;
        tick();
        bus.ext_ack = 1'b0;
        check("idle_ext_ack", 32'(bus.gb_ack), 32'h0);
        tick();

        // Ext read, stub acks during the third strobe cycle
        bus.gb_addr = 24'h201;
        bus.gb_re   = 1'b1;
        tick();
        bus.gb_re = 1'b0;
        check("ext_re_c1", 32'(bus.ext_re), 32'h1);
        check("ext_addr", 32'(bus.ext_addr), 32'h1);
        tick();
        check("ext_re_c2", 32'(bus.ext_re), 32'h1);
        tick();
        check("ext_re_c3", 32'(bus.ext_re), 32'h1);
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 8'h7E;
        tick();
        bus.ext_ack = 1'b0;
        check("ext_re_c4", 32'(bus.ext_re), 32'h0);
        check("ext_ack_c4", 32'(bus.gb_ack), 32'h1);
        check("ext_rdata", bus.gb_rdata, 32'h0000_007E);
        tick();

`ifdef SUBMOD_BANK_TIMEOUT_EN
        host_req(1'b1, 1'b0, 24'h202, 32'h99, 40, rd, lat);
        check("tmo_wr_lat", 32'(lat), 32'd17);
        host_req(1'b0, 1'b1, 24'h002, 32'h0, 10, rd, lat);
        check("tmo_count", {24'h0, rd[7:0]}, 32'h1);
        host_req(1'b0, 1'b1, 24'h203, 32'h0, 40, rd, lat);
        check("tmo_rd_lat", 32'(lat), 32'd17);
        check("tmo_rd_val", rd, 32'hFFFF_FFFF);
`else
        bus.gb_addr  = 24'h202;
        bus.gb_wdata = 32'h99;
        bus.gb_we    = 1'b1;
        tick();
        bus.gb_we = 1'b0;
        ack_seen  = 0;
        for (int c = 1; c < 30; c++) begin
            if (bus.gb_ack) ack_seen++;
            tick();
        end
        check("nowait_ack", 32'(ack_seen), 32'h0);
        check("nowait_we", 32'(bus.ext_we), 32'h1);
        check("nowait_wdata", 32'(bus.ext_wdata), 32'h99);
        bus.ext_ack = 1'b1;
        tick();
        bus.ext_ack = 1'b0;
        check("late_ack", 32'(bus.gb_ack), 32'h1);
        check("late_we", 32'(bus.ext_we), 32'h0);
        tick();
        host_req(1'b0, 1'b1, 24'h002, 32'h0, 10, rd, lat);
        check("tmo_count", {24'h0, rd[7:0]}, 32'h0);
`endif

        // Overrun: second read one cycle into a pending local read
        bus.gb_addr = 24'h000;
        bus.gb_re   = 1'b1;
        tick();
        bus.gb_addr = 24'h001;
        tick();
        bus.gb_re = 1'b0;
        check("ovr_ack", 32'(bus.gb_ack), 32'h1);
        check("ovr_val", bus.gb_rdata, 32'h0BA2_0002);
        ack_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.gb_ack) ack_seen++;
        end
        check("ovr_single", 32'(ack_seen), 32'h0);
        host_req(1'b0, 1'b1, 24'h002, 32'h0, 10, rd, lat);
        check("ovr_count", {24'h0, rd[15:8]}, 32'h1);
        host_req(1'b1, 1'b0, 24'h002, 32'h0, 10, rd, lat);
        host_req(1'b0, 1'b1, 24'h002, 32'h0, 10, rd, lat);
        check("status_clr", rd, 32'h0);

        // Reset during EXT_WAIT
        bus.gb_addr = 24'h201;
        bus.gb_re   = 1'b1;
        tick();
        bus.gb_re = 1'b0;
        tick();
        check("pre_rst_re", 32'(bus.ext_re), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_re_drop", 32'(bus.ext_re), 32'h0);
        ack_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.gb_ack) ack_seen++;
        end
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.gb_ack) ack_seen++;
        end
        check("rst_no_ack", 32'(ack_seen), 32'h0);
        host_req(1'b0, 1'b1, 24'h000, 32'h0, 10, rd, lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_id", rd, 32'h0BA2_0002);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
